// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a small byte FIFO in front of the shifter.
// The pin register follows the FSM state by one clock, so every line level lasts exactly CLKS_PER_BIT clocks.
module uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx_pin,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            pin_q, pin_d;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            push, pop, baud_last, fifo_nonempty;

  assign tx_ready      = (level_q != LEVEL_FULL);
  assign push          = tx_valid && tx_ready;
  assign baud_last     = (baud_q == BAUD_LAST);
  assign fifo_nonempty = (level_q != '0);
  assign uart_tx_pin   = pin_q;
  assign busy          = (state_q != IDLE) || fifo_nonempty;
  assign level         = level_q;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pin_d   = 1'b1;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        pin_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        pin_d = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        pin_d = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames have no idle gap.
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      pin_q    <= 1'b1;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pin_q   <= pin_d;
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage needs no reset: stale bytes are unreachable once the pointers clear.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx: reset, single frame, back-to-back, full FIFO, async reset.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB   = 104;
  localparam int FRAME = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, uart_tx_pin, busy;
  logic [2:0] level;

  int n_assert = 0;
  int n_fail   = 0;
  int waits;
  int low_cnt;
  int busy_cnt;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_tx_pin(uart_tx_pin),
    .busy       (busy),
    .level      (level)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL timeout: observed no end of test, required end before 1 ms");
    $fatal(1, "simulation timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the negedge holding the first start-bit sample; returns on the negedge after the last stop clock.
  task automatic rx_frame(output logic [7:0] b, output int glitches, output logic busy_pen,
                          output logic busy_last, output logic start_bit, output logic stop_bit);
    logic [9:0] bits;
    bits     = '0;
    glitches = 0;
    busy_pen = 1'b0;
    busy_last = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (i % CPB == 0) bits[i / CPB] = uart_tx_pin;
      else if (uart_tx_pin !== bits[i / CPB]) glitches++;
      if (i == FRAME - 2) busy_pen = busy;
      if (i == FRAME - 1) busy_last = busy;
      @(negedge clock);
    end
    start_bit = bits[0];
    stop_bit  = bits[9];
    b         = bits[8:1];
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp_byte, input logic exp_busy_last);
    logic [7:0] b;
    int         g;
    logic       bp, bl, sb, pb;
    rx_frame(b, g, bp, bl, sb, pb);
    chk({tag, "_start"}, sb, 1'b0);
    chk({tag, "_stop"}, pb, 1'b1);
    chk({tag, "_data"}, b, exp_byte);
    chk({tag, "_bit_width"}, g, 0);
    chk({tag, "_busy_stop"}, bp, 1'b1);
    chk({tag, "_busy_after"}, bl, exp_busy_last);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_pin", uart_tx_pin, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_level", level, 3'd0);
    @(negedge clock);

    // Single byte 0x55 while idle
    tx_data = 8'h55; tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    chk("single_level_push", level, 3'd1);
    chk("single_pin_n1", uart_tx_pin, 1'b1);
    @(negedge clock);
    chk("single_level_pop", level, 3'd0);
    chk("single_busy", busy, 1'b1);
    chk("single_pin_n2", uart_tx_pin, 1'b1);
    @(negedge clock);
    chk("single_pin_low", uart_tx_pin, 1'b0);
    check_frame("single", 8'h55, 1'b0);
    chk("single_idle_pin", uart_tx_pin, 1'b1);
    chk("single_idle_busy", busy, 1'b0);

    // Back-to-back 0xA5, 0x00, 0xFF
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clock);
    tx_data = 8'h00;
    @(negedge clock);
    chk("b2b_pushpop_level", level, 3'd1);
    tx_data = 8'hFF;
    @(negedge clock);
    tx_valid = 1'b0;
    chk("b2b_level", level, 3'd2);
    check_frame("b2b_0", 8'hA5, 1'b1);
    check_frame("b2b_1", 8'h00, 1'b1);
    check_frame("b2b_2", 8'hFF, 1'b0);
    chk("b2b_idle_level", level, 3'd0);

    // Full FIFO: tx_valid held while streaming 0x01..0x06
    tx_data = 8'h01; tx_valid = 1'b1;
    @(negedge clock);
    tx_data = 8'h02;
    @(negedge clock);
    chk("full_pushpop_level", level, 3'd1);
    tx_data = 8'h03;
    @(negedge clock);
    chk("full_pin_low", uart_tx_pin, 1'b0);
    tx_data = 8'h04;
    fork
      check_frame("full_0", 8'h01, 1'b1);
      begin
        @(negedge clock);
        tx_data = 8'h05;
        @(negedge clock);
        chk("full_level4", level, 3'd4);
        chk("full_ready_low", tx_ready, 1'b0);
        tx_data = 8'h06;
        @(negedge clock);
        chk("full_held_level", level, 3'd4);
        waits = 0;
        while (!tx_ready && waits < 3000) begin
          @(negedge clock);
          waits++;
        end
        chk("full_ready_rise_wait", waits, 1036);
        chk("full_level_after_pop", level, 3'd3);
        @(negedge clock);
        chk("full_level_refill", level, 3'd4);
        tx_valid = 1'b0;
      end
    join
    check_frame("full_1", 8'h02, 1'b1);
    check_frame("full_2", 8'h03, 1'b1);
    check_frame("full_3", 8'h04, 1'b1);
    check_frame("full_4", 8'h05, 1'b1);
    check_frame("full_5", 8'h06, 1'b0);
    chk("full_idle_level", level, 3'd0);

    // Async reset during a start bit with one byte queued
    tx_data = 8'h00; tx_valid = 1'b1;
    @(negedge clock);
    tx_data = 8'h3C;
    @(negedge clock);
    tx_valid = 1'b0;
    @(negedge clock);
    chk("ar_pin_low", uart_tx_pin, 1'b0);
    chk("ar_level_before", level, 3'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_pin", uart_tx_pin, 1'b1);
    chk("ar_ready", tx_ready, 1'b1);
    chk("ar_busy", busy, 1'b0);
    chk("ar_level", level, 3'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset during bit 3 of 0x0F with two bytes queued
    tx_data = 8'h0F; tx_valid = 1'b1;
    @(negedge clock);
    tx_data = 8'h11;
    @(negedge clock);
    tx_data = 8'h22;
    @(negedge clock);
    tx_valid = 1'b0;
    chk("mid_level_queued", level, 3'd2);
    repeat (4 * CPB + 50) @(negedge clock);
    chk("mid_bit3_pin", uart_tx_pin, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_pin", uart_tx_pin, 1'b1);
    chk("mid_level", level, 3'd0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_ready", tx_ready, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    low_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clock);
      if (uart_tx_pin !== 1'b1) low_cnt++;
      if (busy !== 1'b0) busy_cnt++;
    end
    chk("post_reset_low_samples", low_cnt, 0);
    chk("post_reset_busy_samples", busy_cnt, 0);
    chk("post_reset_level", level, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
